// File: rtl/rr_arb_pkg.sv
// Shared types, defaults and rotation helper for the round-robin bus arbiter.
package rr_arb_pkg;

  localparam int unsigned DEF_NUM_REQ  = 4;
  localparam int unsigned DEF_MAX_HOLD = 16;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational rotating-priority picker: first set req bit scanning ptr+1, ptr+2, ... mod NUM_REQ.
module rr_arb_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDW-1:0]     winner_id,
  output logic               any_valid
);

  logic [IDW-1:0] idx;

  always_comb begin
    winner    = '0;
    winner_id = '0;
    any_valid = 1'b0;
    idx       = ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IDW'(next_idx(32'(idx), NUM_REQ));
      if (!any_valid && req[idx]) begin
        any_valid   = 1'b1;
        winner[idx] = 1'b1;
        winner_id   = idx;
      end
    end
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter with bus-hold semantics and zero-bubble hand-over.
// Optional forced hand-over after MAX_HOLD owned cycles: define RR_ARB_TIMEOUT_EN.
module rr_bus_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDW-1:0]     grant_id,
  output logic               busy
);

  arb_state_t         state, state_n;
  logic [NUM_REQ-1:0] grant_n, pick_req, win;
  logic [IDW-1:0]     id_n, win_id, last_ptr, ptr_n;
  logic               any_other, owner_req, expired;

  // Masking the owner out lets the same picker serve both release and forced hand-over;
  // last_ptr equals the owner while owning, so the scan starts at owner+1.
  assign pick_req = req & ~grant;

  rr_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req       (pick_req),
    .ptr       (last_ptr),
    .winner    (win),
    .winner_id (win_id),
    .any_valid (any_other)
  );

  assign owner_req   = req[grant_id];
  assign grant_valid = (state == OWN);
  assign busy        = grant_valid & owner_req;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned HCW = $clog2(MAX_HOLD + 1);
  logic [HCW-1:0] hold_cnt;

  assign expired = (hold_cnt >= HCW'(MAX_HOLD - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (state_n == IDLE || grant_n != grant) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HCW'(MAX_HOLD)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  logic unused_max_hold;
  assign unused_max_hold = ^32'(MAX_HOLD);
  assign expired         = 1'b0;
`endif

  always_comb begin
    state_n = state;
    grant_n = grant;
    id_n    = grant_id;
    ptr_n   = last_ptr;
    case (state)
      IDLE: begin
        if (any_other) begin
          state_n = OWN;
          grant_n = win;
          id_n    = win_id;
          ptr_n   = win_id;
        end
      end
      OWN: begin
        if (!owner_req || (expired && any_other)) begin
          if (any_other) begin
            grant_n = win;
            id_n    = win_id;
            ptr_n   = win_id;
          end else begin
            state_n = IDLE;
            grant_n = '0;
            id_n    = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        id_n    = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      last_ptr <= IDW'(NUM_REQ - 1);
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      grant_id <= id_n;
      last_ptr <= ptr_n;
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter: directed scenarios plus randomized traffic vs a behavioural model.
module tb_rr_bus_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req   = '0;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: owner (-1 = idle), last owner, owned-cycle count.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_cnt   = 0;

  rr_bus_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic model_edge(input logic rst, input logic [N-1:0] r);
    logic [N-1:0] others;
    bit force_ho;
    int w;
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_cnt = 0;
      return;
    end
    others = r;
    if (m_owner >= 0) others[m_owner] = 1'b0;
    force_ho = 0;
`ifdef RR_ARB_TIMEOUT_EN
    force_ho = (m_owner >= 0) && (m_cnt >= MH - 1) && (others != 0);
`endif
    if (m_owner >= 0 && r[m_owner] && !force_ho) begin
      if (m_cnt < MH) m_cnt++;
      return;
    end
    w = -1;
    for (int k = 1; k <= N; k++) begin
      if (w < 0 && others[(m_last + k) % N]) w = (m_last + k) % N;
    end
    m_cnt = 0;
    if (w >= 0) begin
      m_owner = w; m_last = w;
    end else begin
      m_owner = -1;
    end
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic rst = 1'b0);
    @(negedge clock);
    req   = r;
    reset = rst;
    @(posedge clock);
    model_edge(rst, r);
    #1;
  endtask

  task automatic test_reset();
    cyc(4'b1111, 1'b1);
    cyc(4'b0000, 1'b1);
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
    n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", grant_valid); end
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_id got=%0d want=0", grant_id); end
  endtask

  task automatic test_hold();
    cyc(4'b0001);
    n_cmp++; if (grant !== 4'b0001 || grant_valid !== 1'b1 || grant_id !== 2'd0) begin
      n_bad++; $display("FAIL first_grant got=%b/%b/%0d want=0001/1/0", grant, grant_valid, grant_id);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0001);
      n_cmp++; if (grant !== 4'b0001 || busy !== 1'b1) begin
        n_bad++; $display("FAIL hold cyc=%0d got=%b busy=%b want=0001 busy=1", i, grant, busy);
      end
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] all, drop;
    int e;
    all = 4'b1111;
    cyc(4'b0000, 1'b1);
    cyc(all);
    for (int k = 0; k < 5; k++) begin
      e = k % N;
      for (int j = 0; j < 3; j++) begin
        n_cmp++; if (grant_id !== 2'(e) || grant_valid !== 1'b1) begin
          n_bad++; $display("FAIL rotation k=%0d j=%0d got_id=%0d valid=%b want_id=%0d valid=1", k, j, grant_id, grant_valid, e);
        end
        drop = all;
        if (j == 2) drop[e] = 1'b0;
        cyc(drop);
      end
    end
    n_cmp++; if (grant_id !== 2'd1) begin n_bad++; $display("FAIL rotation_end got=%0d want=1", grant_id); end
  endtask

  task automatic test_wrap();
    cyc(4'b0000, 1'b1);
    cyc(4'b1000);
    n_cmp++; if (grant !== 4'b1000) begin n_bad++; $display("FAIL wrap_setup got=%b want=1000", grant); end
    cyc(4'b0001);
    n_cmp++; if (grant !== 4'b0001 || grant_id !== 2'd0 || grant_valid !== 1'b1) begin
      n_bad++; $display("FAIL wrap got=%b id=%0d want=0001 id=0", grant, grant_id);
    end
  endtask

  task automatic test_release_idle();
    cyc(4'b0000, 1'b1);
    cyc(4'b0010);
    cyc(4'b0000);
    n_cmp++; if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      n_bad++; $display("FAIL release_idle got=%b/%b/%0d want=0000/0/0", grant, grant_valid, grant_id);
    end
    cyc(4'b0100);
    n_cmp++; if (grant_id !== 2'd2 || grant !== 4'b0100) begin
      n_bad++; $display("FAIL after_idle got=%b id=%0d want=0100 id=2", grant, grant_id);
    end
  endtask

  task automatic test_reset_mid();
    cyc(4'b0000, 1'b1);
    cyc(4'b0100);
    cyc(4'b0100, 1'b1);
    n_cmp++; if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid got=%b valid=%b want=0000 valid=0", grant, grant_valid);
    end
    cyc(4'b0110);
    n_cmp++; if (grant_id !== 2'd1) begin n_bad++; $display("FAIL reset_mid_rearb got=%0d want=1", grant_id); end
  endtask

`ifdef RR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    cyc(4'b0000, 1'b1);
    cyc(4'b0001);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0011);
      n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL timeout_hold i=%0d got=%0d want=0", i, grant_id); end
    end
    cyc(4'b0011);
    n_cmp++; if (grant_id !== 2'd1) begin n_bad++; $display("FAIL timeout_handover got=%0d want=1", grant_id); end
    cyc(4'b0000, 1'b1);
    for (int i = 0; i < 12; i++) cyc(4'b0001);
    n_cmp++; if (grant_id !== 2'd0 || grant_valid !== 1'b1) begin
      n_bad++; $display("FAIL timeout_alone got=%0d valid=%b want=0 valid=1", grant_id, grant_valid);
    end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] r, eg;
    logic rst;
    cyc(4'b0000, 1'b1);
    for (int i = 0; i < 400; i++) begin
      r = N'($urandom);
      if (m_owner >= 0 && $urandom_range(3) != 0) r[m_owner] = 1'b1;
      if ($urandom_range(7) == 0) r = '0;
      rst = ($urandom_range(59) == 0);
      cyc(r, rst);
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      n_cmp++; if (grant !== eg) begin n_bad++; $display("FAIL rand_grant i=%0d got=%b want=%b", i, grant, eg); end
      n_cmp++; if (grant_valid !== (m_owner >= 0)) begin
        n_bad++; $display("FAIL rand_valid i=%0d got=%b want=%b", i, grant_valid, m_owner >= 0);
      end
      n_cmp++; if (grant_id !== 2'((m_owner >= 0) ? m_owner : 0)) begin
        n_bad++; $display("FAIL rand_id i=%0d got=%0d want=%0d", i, grant_id, (m_owner >= 0) ? m_owner : 0);
      end
      n_cmp++; if (busy !== (m_owner >= 0 && r[m_owner])) begin
        n_bad++; $display("FAIL rand_busy i=%0d got=%b want=%b", i, busy, m_owner >= 0 && r[m_owner]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_rotation();
    test_wrap();
    test_release_idle();
    test_reset_mid();
`ifdef RR_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
- Parametrised round-robin bus arbiter for NUM_REQ requesters with bus-hold (lock) semantics.
- The current owner keeps the grant for as long as it holds its request. On release, the next owner is picked by rotating priority starting after the last owner.
- Sits between the bus masters and the shared-bus mux. grant_id drives the mux select directly.

Parameters:
- NUM_REQ, 4, number of requesters (2..32).
- IDW, $clog2(NUM_REQ), width of grant_id (derived localparam, not overridable).
- MAX_HOLD, 16, maximum consecutive owned cycles before forced hand-over (used only with RR_ARB_TIMEOUT_EN).

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- req  in  NUM_REQ  request vector, bit i = requester i; level, held while the bus is needed.
- grant  out  NUM_REQ  registered one-hot grant, all-zero when the bus is idle.
- grant_valid  out  1  registered, equals OR of grant.
- grant_id  out  IDW  registered encoded index of the owner; 0 when grant_valid=0.
- busy  out  1  combinational: grant_valid & req[grant_id] (owner still holding).

Behaviour:
- Reset (synchronous, active-high): grant=0, grant_valid=0, grant_id=0, last_ptr=NUM_REQ-1, hold_cnt=0. With this pointer, req[0] has top priority on the first arbitration. Reset asserted mid-ownership drops the grant on the next edge regardless of req.
- States: IDLE (grant_valid=0) and OWN (grant_valid=1).
- IDLE, req==0: stay IDLE.
- IDLE, req!=0: on the next edge, grant the first set req bit scanning last_ptr+1, last_ptr+2, ... modulo NUM_REQ. Go to OWN; last_ptr <= winner. Latency from req to grant is 1 cycle.
- OWN, req[grant_id]=1: grant unchanged (hold).
- OWN, req[grant_id]=0, other req pending: zero-bubble hand-over. On the same edge, grant the next winner by rotation from the current owner and stay in OWN.
- OWN, req[grant_id]=0, no other req: go to IDLE, grant=0.
- Rotation scan starts at owner+1, so the old owner ranks last in any re-arbitration. The last index wraps to index 0.
- Simultaneous release by the owner and a new request by the same requester: the old owner can re-win only if no other request is pending.
- Requests from non-owners never disturb an active hold.
- grant is always one-hot or zero. grant_id, grant and grant_valid always change on the same edge.

Optional Feature:
- Macro RR_ARB_TIMEOUT_EN.
- Defined: hold_cnt counts owned cycles, saturating at MAX_HOLD and cleared on every ownership change.
  - If hold_cnt==MAX_HOLD-1 and any other req bit is set, the next edge forces a hand-over to the rotation winner, even with the owner's req still high.
  - If no other request is pending, the owner keeps the bus and hold_cnt stays saturated.
- Not defined: no counter is built; the owner may hold indefinitely. MAX_HOLD is ignored.

Decomposition:
- Package rr_arb_pkg: state enum (IDLE, OWN), localparam function for the next rotation index, shared default constants.
- Sub-module rr_arb_pick: purely combinational rotating-priority picker. Inputs are req vector and start pointer; outputs are one-hot winner, encoded index and any_valid.
- rr_bus_arbiter holds the state register, pointer, hold counter and output registers.

Test Plan:
- Reset, then req=4'b0001: grant=4'b0001, grant_id=0, grant_valid=1 one cycle later; hold for 10 cycles while req0 stays high.
- req=4'b1111 from IDLE, each owner drops req for 1 cycle after 3 owned cycles then re-raises: grant sequence is 0,1,2,3,0 with zero idle cycles between owners.
- Owner 3 releases while req=4'b0001: next grant=4'b0001 (wrap-around), grant_id=0.
- Owner 1 releases with req=0: grant=0, grant_valid=0, grant_id=0 on the next edge. Then req=4'b0100: grant_id=2 (last_ptr=1).
- Reset asserted while grant=4'b0100 and req2 high: grant=0 on the next edge; after reset release, req=4'b0110 gives grant_id=1.
- RR_ARB_TIMEOUT_EN, MAX_HOLD=4: req0 held permanently, req1 raised at cycle 1 → grant moves to 1 after exactly 4 owned cycles by requester 0. With only req0 held, requester 0 keeps the grant indefinitely.
